mem_stage_sram_ctrl: RTL and testbench

- Sequences every MEM-stage data access onto an external 16-bit asynchronous SRAM.
- Sits between the EXE/MEM pipeline register outputs (mem_read, mem_write, ALU address, store data) and the SRAM pins.
- Splits each 32-bit word into two 16-bit half accesses with programmable wait states.
- Holds ready low to freeze the pipeline until the access completes.

---
 rtl/mem_stage_sram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM-stage controller for a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two halfword accesses (LO then HI). Each half
// is held on the bus for WAIT_CYCLES cycles. ready stays low meanwhile so the
// pipeline is frozen.
// Optional build macro SRAM_LAST_READ_CACHE_EN adds a one-entry
// {valid, word, data} cache. With it, a repeat read completes in the request
// cycle without touching the SRAM.
//
// Handshake: ready is combinational. ready=1 means "no access pending or the
// access completes this cycle". The pipeline advances on the clock edge that
// ends a ready=1 cycle. A request must be held until that edge.
// Once LO, HI or DONE is entered, request changes are ignored.
module mem_stage_sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               r_is_wr;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_sram_dq_out;
    logic               r_sram_dq_oe;
    logic               r_sram_we_n;
    logic               r_sram_oe_n;

    logic               w_req;
    logic               w_hit;
    logic [SRAM_AW-2:0] w_word;
    logic               w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_word        = addr[SRAM_AW:2];
    assign w_unused_addr = ^{addr[31:SRAM_AW+1], addr[1:0]};

`ifdef SRAM_LAST_READ_CACHE_EN
    logic               r_c_valid;
    logic [SRAM_AW-2:0] r_c_word;
    logic [31:0]        r_c_data;

    // Repeat read of the last word touched: served from the entry in IDLE.
    assign w_hit = (r_state == S_IDLE) && mem_read && !mem_write &&
                   r_c_valid && (r_c_word == w_word);
    assign rdata = w_hit ? r_c_data : r_rdata;
`else
    assign w_hit = 1'b0;
    assign rdata = r_rdata;
`endif

    // Freeze the pipeline while a request is pending or an access is in flight.
    assign ready = (r_state == S_DONE) ||
                   ((r_state == S_IDLE) && (!w_req || w_hit));

    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;
    assign sram_we_n   = r_sram_we_n;
    assign sram_oe_n   = r_sram_oe_n;
    assign o_dbg_state = r_state;

    // Access sequencer: the state, the wait counter, the registered pins and the read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_is_wr       <= 1'b0;
            r_word        <= '0;
            r_wdata       <= 32'd0;
            r_rdata       <= 32'd0;
            r_sram_addr   <= '0;
            r_sram_dq_out <= 16'd0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
`ifdef SRAM_LAST_READ_CACHE_EN
            r_c_valid     <= 1'b0;
            r_c_word      <= '0;
            r_c_data      <= 32'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
`ifdef SRAM_LAST_READ_CACHE_EN
                        r_rdata <= r_c_data;
`endif
                    end else if (w_req) begin
                        // A store wins when both requests are raised.
                        r_is_wr       <= mem_write;
                        r_word        <= w_word;
                        r_wdata       <= wdata;
                        r_cnt         <= 4'd0;
                        r_state       <= S_LO;
                        r_sram_addr   <= {w_word, 1'b0};
                        r_sram_dq_out <= mem_write ? wdata[15:0] : 16'd0;
                        r_sram_dq_oe  <= mem_write;
                        r_sram_we_n   <= !mem_write;
                        r_sram_oe_n   <= mem_write;
                    end
                end
                S_LO: begin
                    if (r_cnt == LAST_CNT) begin
                        if (!r_is_wr) begin
                            r_rdata[15:0] <= sram_dq_in;
                        end
                        r_cnt         <= 4'd0;
                        r_state       <= S_HI;
                        r_sram_addr   <= {r_word, 1'b1};
                        r_sram_dq_out <= r_is_wr ? r_wdata[31:16] : 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HI: begin
                    if (r_cnt == LAST_CNT) begin
                        if (!r_is_wr) begin
                            r_rdata[31:16] <= sram_dq_in;
                        end
                        r_cnt         <= 4'd0;
                        r_state       <= S_DONE;
                        r_sram_dq_out <= 16'd0;
                        r_sram_dq_oe  <= 1'b0;
                        r_sram_we_n   <= 1'b1;
                        r_sram_oe_n   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef SRAM_LAST_READ_CACHE_EN
                    r_c_valid <= 1'b1;
                    r_c_word  <= r_word;
                    r_c_data  <= r_is_wr ? r_wdata : r_rdata;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: bench for mem_stage_sram_ctrl with a behavioural
// SRAM and a word-level reference model of memory, rdata and the last-access cache.
module tb_mem_stage_sram_ctrl;

  localparam int W   = 2;
  localparam int AW  = 18;
  localparam int LAT = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic [1:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .o_dbg_state (dbg_state)
  );

  // ---------------- behavioural SRAM ----------------
  logic [15:0] sram_mem [0:1023];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[9:0]] <= sram_dq_out;
  end
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[9:0]];

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [0:255];
  logic [31:0] m_rdata;
  logic        m_cv;
  int          m_cw;
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat_f(input logic rd, input logic wr, input int w);
`ifdef SRAM_LAST_READ_CACHE_EN
    if (rd && !wr && m_cv && m_cw == w) return 0;
`endif
    return LAT;
  endfunction

  task automatic model_update(input logic rd, input logic wr, input int w,
                              input logic [31:0] d, input logic hit);
    if (hit) begin
      m_rdata = ref_mem[w];
    end else begin
      if (wr) ref_mem[w] = d;
      else if (rd) m_rdata = ref_mem[w];
      m_cv = 1'b1;
      m_cw = w;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 of the request cycle. It returns the index of the ready cycle, or -1 on timeout.
  task automatic wait_ready(output int lat, output logic [31:0] data);
    lat  = -1;
    data = 32'd0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ready) begin
        lat  = k;
        data = rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data);
    int w, el, lat;
    logic [31:0] got;
    w  = int'(a[9:2]);
    el = exp_lat_f(rd, wr, w);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    wait_ready(lat, got);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(el));
    check({tag, " rdata"}, got, exp_data);
    model_update(rd, wr, w, d, el == 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [31:0] got;
    logic [31:0] r, a, d;
    int w, kind;
    logic rd, wr;

    n_checks = 0; n_fail = 0;
    m_rdata = 32'd0; m_cv = 1'b0; m_cw = 0;
    for (int i = 0; i < 1024; i++) sram_mem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;

    tbl[0] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_2222, 32'h1234_5678};
    tbl[3] = '{1'b0, 1'b1, 32'h0000_0004, 32'h3333_4444, 32'h1234_5678};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 1'b0, 32'hFFF8_0020, 32'h0,         32'h1234_5678};
    tbl[6] = '{1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_5A5A, 32'h1234_5678};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_5A5A};
    tbl[8] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_2222};
    tbl[9] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0,         32'h1111_2222};

    mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset we_n", 32'(sram_we_n), 32'd1);
    check("reset oe_n", 32'(sram_oe_n), 32'd1);
    check("reset dq_oe", 32'(sram_dq_oe), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset sram_addr", 32'(sram_addr), 32'd0);
    check("reset dq_out", 32'(sram_dq_out), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Store 0x10 with a per-cycle pin check.
    mem_write = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("wr c%0d ready", k), 32'(ready), 32'(k == LAT));
      if (k >= 1 && k <= 2 * W) begin
        check($sformatf("wr c%0d addr", k), 32'(sram_addr), (k <= W) ? 32'h8 : 32'h9);
        check($sformatf("wr c%0d dq", k), 32'(sram_dq_out), (k <= W) ? 32'hBEEF : 32'hDEAD);
        check($sformatf("wr c%0d we_n", k), 32'(sram_we_n), 32'd0);
        check($sformatf("wr c%0d dq_oe", k), 32'(sram_dq_oe), 32'd1);
        check($sformatf("wr c%0d oe_n", k), 32'(sram_oe_n), 32'd1);
      end else begin
        check($sformatf("wr c%0d we_n", k), 32'(sram_we_n), 32'd1);
        check($sformatf("wr c%0d dq_oe", k), 32'(sram_dq_oe), 32'd0);
      end
      @(posedge clk); #1;
      if (k == LAT) begin mem_write = 1'b0; end
    end
    model_update(1'b0, 1'b1, 4, 32'hDEAD_BEEF, 1'b0);

    // Reset pulse in the HI phase of a store to 0x100 (word never read back).
    mem_write = 1'b1; addr = 32'h100; wdata = 32'hCAFE_F00D;
    repeat (2 * W - 1) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort pre we_n", 32'(sram_we_n), 32'd0);
    check("abort pre addr", 32'(sram_addr), 32'h81);
    #1 mem_write = 1'b0; rst = 1'b0;
    #1;
    check("abort we_n", 32'(sram_we_n), 32'd1);
    check("abort dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort ready", 32'(ready), 32'd1);
    check("abort state", 32'(dbg_state), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    m_rdata = 32'd0; m_cv = 1'b0;
    check("abort rdata", rdata, 32'd0);

    // Load 0x10 with a per-cycle pin check. The cache is empty after reset.
    mem_read = 1'b1; addr = 32'h10;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("rd c%0d ready", k), 32'(ready), 32'(k == LAT));
      check($sformatf("rd c%0d we_n", k), 32'(sram_we_n), 32'd1);
      if (k >= 1 && k <= 2 * W) begin
        check($sformatf("rd c%0d oe_n", k), 32'(sram_oe_n), 32'd0);
        check($sformatf("rd c%0d addr", k), 32'(sram_addr), (k <= W) ? 32'h8 : 32'h9);
        check($sformatf("rd c%0d dq_oe", k), 32'(sram_dq_oe), 32'd0);
      end
      if (k == LAT) check("rd data", rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      if (k == LAT) mem_read = 1'b0;
    end
    model_update(1'b1, 1'b0, 4, 32'd0, 1'b0);

    // Table of vectors.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp_rdata);
    end

    // Back-to-back loads of 0x0 and 0x4: IDLE then LO after the first DONE.
    mem_read = 1'b1; addr = 32'h0;
    wait_ready(lat, got);
    check("b2b first latency", 32'(lat), 32'(exp_lat_f(1'b1, 1'b0, 0)));
    check("b2b first data", got, 32'h1111_2222);
    model_update(1'b1, 1'b0, 0, 32'd0, 1'b0);
    @(posedge clk); #1;
    addr = 32'h4;
    @(negedge clk);
    check("b2b idle ready", 32'(ready), 32'd0);
    check("b2b idle oe_n", 32'(sram_oe_n), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b lo oe_n", 32'(sram_oe_n), 32'd0);
    check("b2b lo addr", 32'(sram_addr), 32'h2);
    @(posedge clk); #1;
    // Counting restarts at the second LO cycle, so ready follows LAT-2 cycles later.
    wait_ready(lat, got);
    @(posedge clk); #1;
    mem_read = 1'b0;
    check("b2b second latency", 32'(lat), 32'(LAT - 2));
    check("b2b second data", got, 32'h3333_4444);
    model_update(1'b1, 1'b0, 1, 32'd0, 1'b0);

`ifdef SRAM_LAST_READ_CACHE_EN
    // Repeat load of 0x4 is served from the cache entry.
    mem_read = 1'b1; addr = 32'h4;
    @(negedge clk);
    check("cache ready", 32'(ready), 32'd1);
    check("cache rdata", rdata, 32'h3333_4444);
    check("cache oe_n", 32'(sram_oe_n), 32'd1);
    check("cache sram_addr", 32'(sram_addr), 32'h3);
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("cache held rdata", rdata, 32'h3333_4444);
    check("cache state", 32'(dbg_state), 32'd0);
    check("cache oe_n after", 32'(sram_oe_n), 32'd1);
    @(posedge clk); #1;
    model_update(1'b1, 1'b0, 1, 32'd0, 1'b1);
`endif

    // Random traffic against the word-level reference.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      w = $urandom_range(0, 15);
      r = $urandom;
      a = (r & 32'hFFF8_0000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      run_op($sformatf("rnd%0d", i), rd, wr, a, d, wr ? m_rdata : ref_mem[w]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
